// File: rtl/alu_seq_pkg.sv
// Shared types and sizing for the ALU command sequencer and its register file.
package alu_seq_pkg;

  localparam int REG_IDX_W  = 2;
  localparam int DATA_W     = 16;
  localparam int FUNC_W     = 3;
  localparam int SETTLE_MAX = 15;
  localparam int NUM_REGS   = 1 << REG_IDX_W;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Counter preload so that capture lands exactly SETTLE_CYCLES edges after accept.
  function automatic logic [CNT_W-1:0] settle_load(input int settle);
    return CNT_W'(settle - 1);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x16 register file: one synchronous write port, three combinational read ports.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] raddr_a,
  output logic [DATA_W-1:0]    rdata_a,
  input  logic [REG_IDX_W-1:0] raddr_b,
  output logic [DATA_W-1:0]    rdata_b,
  input  logic [REG_IDX_W-1:0] raddr_c,
  output logic [DATA_W-1:0]    rdata_c
);

  logic [DATA_W-1:0] regs_r [NUM_REGS];

  // Register storage with a single write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_r <= '{default: '0};
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_r[raddr_a];
  assign rdata_b = regs_r[raddr_b];
  assign rdata_c = regs_r[raddr_c];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end for an external combinational ALU: operand fetch, settle hold,
// result write-back and a one-cycle response strobe.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [FUNC_W-1:0]    cmd_func,
  input  logic                 cmd_cin,
  input  logic [REG_IDX_W-1:0] cmd_srca,
  input  logic [REG_IDX_W-1:0] cmd_srcb,
  input  logic                 cmd_use_imm,
  input  logic [DATA_W-1:0]    cmd_imm,
  input  logic [REG_IDX_W-1:0] cmd_dst,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic                 alu_cin,
  output logic [FUNC_W-1:0]    alu_func,
  input  logic [DATA_W-1:0]    alu_w,
  input  logic                 alu_zero,
  input  logic                 alu_neg,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_zero,
  output logic                 rsp_neg,
  input  logic [REG_IDX_W-1:0] rd_sel,
  output logic [DATA_W-1:0]    rd_data
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
    $error("alu_op_sequencer: SETTLE_CYCLES must be in 1..15");
  end

  seq_state_e           state_r, state_s;
  logic                 accept_s, capture_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [REG_IDX_W-1:0] dst_r;
  logic [DATA_W-1:0]    rf_a_s, rf_b_s;
  logic [DATA_W-1:0]    alu_a_r, alu_b_r, rsp_data_r;
  logic                 alu_cin_r, rsp_zero_r, rsp_neg_r, rsp_valid_r, cmd_ready_r;
  logic [FUNC_W-1:0]    alu_func_r;

  alu_seq_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (capture_s),
    .waddr   (dst_r),
    .wdata   (alu_w),
    .raddr_a (cmd_srca),
    .rdata_a (rf_a_s),
    .raddr_b (cmd_srcb),
    .rdata_b (rf_b_s),
    .raddr_c (rd_sel),
    .rdata_c (rd_data)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode plus the accept and capture strobes.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          accept_s = 1'b1;
          state_s  = EXEC;
        end else begin
          state_s  = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == '0) begin
          capture_s = 1'b1;
          state_s   = DONE;
        end else begin
          state_s   = EXEC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Settle counter: preloaded at accept, counts down while executing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= settle_load(SETTLE_CYCLES);
    end else if (state_r == EXEC && cnt_r != '0) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Operand registers; sampled only at accept so the ALU sees stable inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_r    <= '0;
      alu_b_r    <= '0;
      alu_cin_r  <= 1'b0;
      alu_func_r <= '0;
      dst_r      <= '0;
    end else if (accept_s) begin
      alu_a_r    <= rf_a_s;
      alu_b_r    <= cmd_use_imm ? cmd_imm : rf_b_s;
      alu_cin_r  <= cmd_cin;
      alu_func_r <= cmd_func;
      dst_r      <= cmd_dst;
    end
  end

  // Response registers; data and flags hold until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_r <= '0;
      rsp_zero_r <= 1'b0;
      rsp_neg_r  <= 1'b0;
    end else if (capture_s) begin
      rsp_data_r <= alu_w;
      rsp_zero_r <= alu_zero;
      rsp_neg_r  <= alu_neg;
    end
  end

  // Handshake outputs registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      cmd_ready_r <= (state_s == IDLE);
      rsp_valid_r <= (state_s == DONE);
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_zero  = rsp_zero_r;
  assign rsp_neg   = rsp_neg_r;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_cin   = alu_cin_r;
  assign alu_func  = alu_func_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with an adder-style ALU stub.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_cin, cmd_use_imm;
  logic [2:0]  cmd_func;
  logic [1:0]  cmd_srca, cmd_srcb, cmd_dst, rd_sel;
  logic [15:0] cmd_imm;
  logic [15:0] alu_a, alu_b, alu_w, rsp_data, rd_data;
  logic        alu_cin, alu_zero, alu_neg, rsp_valid, rsp_zero, rsp_neg;
  logic [2:0]  alu_func;

  int checks = 0;
  int failures = 0;
  logic [15:0] m [4];

  // Observations recorded by do_cmd
  logic        obs_accepted, obs_ready_exec, obs_stable, obs_valid, obs_valid_after, obs_ready_after;
  logic        obs_cin, obs_zero, obs_neg;
  logic [2:0]  obs_func;
  logic [15:0] obs_a, obs_b, obs_data, obs_rd;
  int          obs_lat;

  always #5 clk = ~clk;

  assign alu_w    = alu_a + alu_b + {15'd0, alu_cin};
  assign alu_zero = (alu_w == 16'd0);
  assign alu_neg  = alu_w[15];

  alu_op_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_func(cmd_func), .cmd_cin(cmd_cin), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm), .cmd_dst(cmd_dst),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_func(alu_func),
    .alu_w(alu_w), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
    .rd_sel(rd_sel), .rd_data(rd_data)
  );

  function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b, input logic c);
    int unsigned s;
    s = int'(a) + int'(b) + int'(c);
    return 16'(s % 65536);
  endfunction

  // Drives one command and records what the DUT does with it; comparisons live in the tests.
  task automatic do_cmd(input logic [2:0] f, input logic ci, input logic [1:0] sa,
                        input logic [1:0] sb, input logic ui, input logic [15:0] im,
                        input logic [1:0] d);
    int waitc;
    cmd_func = f; cmd_cin = ci; cmd_srca = sa; cmd_srcb = sb;
    cmd_use_imm = ui; cmd_imm = im; cmd_dst = d; cmd_valid = 1'b1;
    waitc = 0;
    while (!cmd_ready && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    obs_accepted = cmd_ready;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    obs_a = alu_a; obs_b = alu_b; obs_cin = alu_cin; obs_func = alu_func;
    obs_ready_exec = cmd_ready;
    obs_stable = 1'b1;
    obs_lat = 0;
    while (!rsp_valid && obs_lat < 10) begin
      if (alu_a !== obs_a || alu_b !== obs_b || alu_cin !== obs_cin || alu_func !== obs_func)
        obs_stable = 1'b0;
      @(posedge clk); #1; obs_lat++;
    end
    rd_sel = d; #1;
    obs_valid = rsp_valid; obs_data = rsp_data; obs_zero = rsp_zero; obs_neg = rsp_neg;
    obs_rd = rd_data;
    @(posedge clk); #1;
    obs_valid_after = rsp_valid;
    obs_ready_after = cmd_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if ({alu_a, alu_b} !== 32'd0) begin failures++; $display("FAIL reset_alu_ab got=%h exp=0", {alu_a, alu_b}); end
    checks++; if ({alu_cin, alu_func} !== 4'd0) begin failures++; $display("FAIL reset_cin_func got=%h exp=0", {alu_cin, alu_func}); end
    checks++; if ({rsp_data, rsp_zero, rsp_neg} !== 18'd0) begin failures++; $display("FAIL reset_rsp got=%h exp=0", {rsp_data, rsp_zero, rsp_neg}); end
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      checks++; if (rd_data !== 16'd0) begin failures++; $display("FAIL reset_rd%0d got=%h exp=0", i, rd_data); end
    end
    for (int i = 0; i < 4; i++) m[i] = 16'd0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_imm_load;
    do_cmd(3'd0, 1'b0, 2'd0, 2'd3, 1'b1, 16'd5, 2'd1);
    checks++; if (obs_accepted !== 1'b1) begin failures++; $display("FAIL imm_accept got=%b exp=1", obs_accepted); end
    checks++; if (obs_a !== 16'd0 || obs_b !== 16'd5) begin failures++; $display("FAIL imm_operands got=%h/%h exp=0000/0005", obs_a, obs_b); end
    checks++; if (obs_ready_exec !== 1'b0) begin failures++; $display("FAIL imm_ready_busy got=%b exp=0", obs_ready_exec); end
    checks++; if (obs_lat !== 2) begin failures++; $display("FAIL imm_latency got=%0d exp=2", obs_lat); end
    checks++; if (obs_valid !== 1'b1) begin failures++; $display("FAIL imm_rsp_valid got=%b exp=1", obs_valid); end
    checks++; if (obs_data !== 16'd5 || obs_zero !== 1'b0 || obs_neg !== 1'b0) begin failures++; $display("FAIL imm_result got=%h z=%b n=%b exp=0005 z=0 n=0", obs_data, obs_zero, obs_neg); end
    checks++; if (obs_rd !== 16'd5) begin failures++; $display("FAIL imm_writeback got=%h exp=0005", obs_rd); end
    checks++; if (obs_valid_after !== 1'b0 || obs_ready_after !== 1'b1) begin failures++; $display("FAIL imm_after got=v%b r%b exp=v0 r1", obs_valid_after, obs_ready_after); end
    m[1] = 16'd5;
  endtask

  task automatic test_reg_operands;
    do_cmd(3'd2, 1'b1, 2'd1, 2'd1, 1'b0, 16'hDEAD, 2'd2);
    checks++; if (obs_a !== 16'd5 || obs_b !== 16'd5 || obs_cin !== 1'b1) begin failures++; $display("FAIL reg_operands got=%h/%h/%b exp=0005/0005/1", obs_a, obs_b, obs_cin); end
    checks++; if (obs_func !== 3'd2) begin failures++; $display("FAIL reg_func got=%0d exp=2", obs_func); end
    checks++; if (obs_data !== 16'd11 || obs_rd !== 16'd11) begin failures++; $display("FAIL reg_result got=%h rd=%h exp=000b", obs_data, obs_rd); end
    m[2] = 16'd11;
  endtask

  task automatic test_flags;
    do_cmd(3'd0, 1'b0, 2'd2, 2'd0, 1'b1, 16'hFFF5, 2'd3);
    checks++; if (obs_data !== 16'd0 || obs_zero !== 1'b1 || obs_neg !== 1'b0) begin failures++; $display("FAIL flag_zero got=%h z=%b n=%b exp=0000 z=1 n=0", obs_data, obs_zero, obs_neg); end
    m[3] = 16'd0;
    do_cmd(3'd0, 1'b0, 2'd0, 2'd0, 1'b1, 16'h8000, 2'd0);
    checks++; if (obs_data !== 16'h8000 || obs_zero !== 1'b0 || obs_neg !== 1'b1) begin failures++; $display("FAIL flag_neg got=%h z=%b n=%b exp=8000 z=0 n=1", obs_data, obs_zero, obs_neg); end
    m[0] = 16'h8000;
  endtask

  task automatic test_self_src;
    do_cmd(3'd5, 1'b0, 2'd1, 2'd0, 1'b1, 16'h0010, 2'd1);
    checks++; if (obs_a !== 16'd5) begin failures++; $display("FAIL self_src_old got=%h exp=0005", obs_a); end
    checks++; if (obs_rd !== 16'h0015) begin failures++; $display("FAIL self_src_wb got=%h exp=0015", obs_rd); end
    m[1] = 16'h0015;
  endtask

  task automatic test_random;
    logic [2:0] f; logic ci, ui; logic [1:0] sa, sb, d; logic [15:0] im, ea, eb, ew;
    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom_range(0, 7)); ci = 1'($urandom_range(0, 1));
      sa = 2'($urandom_range(0, 3)); sb = 2'($urandom_range(0, 3)); d = 2'($urandom_range(0, 3));
      ui = 1'($urandom_range(0, 1)); im = 16'($urandom);
      if (i % 4 == 0) begin
        ui = 1'b1;
        im = 16'd0 - m[sa] - {15'd0, ci};
      end
      ea = m[sa];
      eb = ui ? im : m[sb];
      ew = ref_sum(ea, eb, ci);
      do_cmd(f, ci, sa, sb, ui, im, d);
      checks++; if (obs_a !== ea || obs_b !== eb || obs_func !== f) begin failures++; $display("FAIL rand%0d_operands got=%h/%h/%0d exp=%h/%h/%0d", i, obs_a, obs_b, obs_func, ea, eb, f); end
      checks++; if (obs_data !== ew || obs_zero !== (ew == 16'd0) || obs_neg !== ew[15]) begin failures++; $display("FAIL rand%0d_result got=%h z=%b n=%b exp=%h", i, obs_data, obs_zero, obs_neg, ew); end
      checks++; if (obs_rd !== ew) begin failures++; $display("FAIL rand%0d_writeback got=%h exp=%h", i, obs_rd, ew); end
      checks++; if (obs_lat !== 2 || obs_stable !== 1'b1) begin failures++; $display("FAIL rand%0d_timing lat=%0d stable=%b exp lat=2 stable=1", i, obs_lat, obs_stable); end
      m[d] = ew;
    end
  endtask

  typedef struct {
    logic [2:0] f; logic ci; logic [1:0] sa; logic [1:0] sb; logic ui; logic [15:0] im; logic [1:0] d;
  } cmd_t;

  task automatic test_back_to_back;
    cmd_t q[3];
    logic [15:0] exp_q[$];
    logic [1:0]  dst_q[$];
    logic [15:0] la, lb, ea, eb;
    logic rdy, vld, stable;
    int acc, rsp, cyc, last_acc, lows;
    q[0] = '{3'd1, 1'b0, 2'd1, 2'd2, 1'b0, 16'h0000, 2'd1};
    q[1] = '{3'd3, 1'b0, 2'd1, 2'd0, 1'b1, 16'($urandom), 2'd2};
    q[2] = '{3'd6, 1'b1, 2'd2, 2'd1, 1'b0, 16'h0000, 2'd3};
    acc = 0; rsp = 0; cyc = 0; last_acc = 0; lows = 0; stable = 1'b1; la = '0; lb = '0;
    cmd_func = q[0].f; cmd_cin = q[0].ci; cmd_srca = q[0].sa; cmd_srcb = q[0].sb;
    cmd_use_imm = q[0].ui; cmd_imm = q[0].im; cmd_dst = q[0].d; cmd_valid = 1'b1;
    while (rsp < 3 && cyc < 60) begin
      if (rsp_valid) begin
        checks++; if (exp_q.size() == 0 || rsp_data !== exp_q[0]) begin failures++; $display("FAIL b2b_rsp%0d got=%h exp=%h", rsp, rsp_data, (exp_q.size() > 0) ? exp_q[0] : 16'hxxxx); end
        if (exp_q.size() > 0) begin
          m[dst_q[0]] = exp_q[0];
          void'(exp_q.pop_front()); void'(dst_q.pop_front());
        end
        rsp++;
      end
      rdy = cmd_ready; vld = cmd_valid;
      if (acc > 0 && !rdy) begin
        lows++;
        if (alu_a !== la || alu_b !== lb) stable = 1'b0;
      end
      @(posedge clk); #1; cyc++;
      if (rdy && vld) begin
        ea = m[q[acc].sa];
        eb = q[acc].ui ? q[acc].im : m[q[acc].sb];
        checks++; if (alu_a !== ea || alu_b !== eb) begin failures++; $display("FAIL b2b_operands%0d got=%h/%h exp=%h/%h", acc, alu_a, alu_b, ea, eb); end
        if (acc > 0) begin
          checks++; if (cyc - last_acc !== 4) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=4", acc, cyc - last_acc); end
        end
        exp_q.push_back(ref_sum(ea, eb, q[acc].ci));
        dst_q.push_back(q[acc].d);
        last_acc = cyc; la = alu_a; lb = alu_b;
        acc++;
        if (acc < 3) begin
          cmd_func = q[acc].f; cmd_cin = q[acc].ci; cmd_srca = q[acc].sa; cmd_srcb = q[acc].sb;
          cmd_use_imm = q[acc].ui; cmd_imm = q[acc].im; cmd_dst = q[acc].d;
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    checks++; if (acc !== 3 || rsp !== 3) begin failures++; $display("FAIL b2b_counts got=acc%0d rsp%0d exp=3/3", acc, rsp); end
    checks++; if (lows !== 9) begin failures++; $display("FAIL b2b_ready_low got=%0d exp=9", lows); end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL b2b_stable got=%b exp=1", stable); end
    rd_sel = 2'd3; #1;
    checks++; if (rd_data !== m[3]) begin failures++; $display("FAIL b2b_r3 got=%h exp=%h", rd_data, m[3]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    int waitc;
    logic saw_valid;
    cmd_func = 3'd0; cmd_cin = 1'b0; cmd_srca = 2'd1; cmd_srcb = 2'd0;
    cmd_use_imm = 1'b1; cmd_imm = 16'h0123; cmd_dst = 2'd2; cmd_valid = 1'b1;
    waitc = 0;
    while (!cmd_ready && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1; #1;
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL abort_handshake got=r%b v%b exp=r1 v0", cmd_ready, rsp_valid); end
    checks++; if ({alu_a, alu_b, rsp_data} !== 48'd0) begin failures++; $display("FAIL abort_regs got=%h exp=0", {alu_a, alu_b, rsp_data}); end
    for (int i = 0; i < 4; i++) m[i] = 16'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL abort_no_rsp got=%b exp=0", saw_valid); end
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      checks++; if (rd_data !== 16'd0) begin failures++; $display("FAIL abort_r%0d got=%h exp=0", i, rd_data); end
    end
    do_cmd(3'd0, 1'b0, 2'd0, 2'd0, 1'b1, 16'd7, 2'd1);
    checks++; if (obs_data !== 16'd7 || obs_rd !== 16'd7) begin failures++; $display("FAIL abort_recover got=%h rd=%h exp=0007", obs_data, obs_rd); end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_func = 3'd0; cmd_cin = 1'b0; cmd_srca = 2'd0; cmd_srcb = 2'd0;
    cmd_use_imm = 1'b0; cmd_imm = 16'd0; cmd_dst = 2'd0; rd_sel = 2'd0;
    test_reset();
    test_imm_load();
    test_reg_operands();
    test_flags();
    test_self_src();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog");
  end

endmodule
